// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL bit
// positions and the bus responder state encoding.
package timer_pkg;

   localparam logic [15:0] TIMER_CTRL     = 16'd0;
   localparam logic [15:0] TIMER_PRESCALE = 16'd1;
   localparam logic [15:0] TIMER_COUNT    = 16'd2;
   localparam logic [15:0] TIMER_COMPARE  = 16'd3;
   localparam logic [15:0] TIMER_STATUS   = 16'd4;

   localparam int CTRL_RUN         = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;

   typedef enum logic {
      IDLE,
      RESP
   } bus_state_e;

endpackage

// File: rtl/memory_bus.sv
// Simple request/acknowledge memory bus: the master holds enable until it sees
// data_ready; the responder returns read data on data_out.
interface memory_bus;

   logic [15:0] address;
   logic [15:0] data_in;
   logic        write_enable;
   logic        enable;
   logic        data_ready;
   logic [15:0] data_out;

   modport master (
      output address, data_in, write_enable, enable,
      input  data_ready, data_out
   );

   modport slave (
      input  address, data_in, write_enable, enable,
      output data_ready, data_out
   );

endinterface

// File: rtl/timer_prescaler.sv
// Divides the clock by (prescale + 1) while running; tick is high for the
// single cycle in which the divider wraps.
module timer_prescaler (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] prescale,
   input  logic        clear,
   output logic        tick
);

   logic [15:0] count_q;

   assign tick = run && (count_q == prescale);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset || !run || clear) begin
         count_q <= '0;
      end else if (tick) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 16'd1;
      end
   end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped prescaled 16-bit timer with compare match, sticky status flag
// and level interrupt; responds on memory_bus with a two-cycle access.
module timer_peripheral
   import timer_pkg::*;
#(
   parameter logic [15:0] RESET_PRESCALE = 16'h0000,
   parameter logic [15:0] RESET_COMPARE  = 16'hFFFF
) (
   input  logic      clock,
   input  logic      reset,
   memory_bus.slave  bus,
   output logic      irq
);

   bus_state_e  state_q, state_d;
   logic        access;
   logic        wr, rd;
   logic [2:0]  ctrl_q;
   logic [15:0] prescale_q, count_q, compare_q;
   logic        match_q;
   logic [15:0] data_out_q;
   logic [15:0] rdata;
   logic        tick, count_wr, set_match, prescale_clear;

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: defaults first so no path through the case leaves a latch behind.
   always_comb begin
      state_d = state_q;
      access  = 1'b0;
      case (state_q)
         IDLE: if (bus.enable) begin
            access  = 1'b1;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign wr             = access && bus.write_enable;
   assign rd             = access && !bus.write_enable;
   assign count_wr       = wr && (bus.address == TIMER_COUNT);
   assign prescale_clear = wr && ((bus.address == TIMER_CTRL) || (bus.address == TIMER_PRESCALE));
   // A bus load of COUNT takes priority over the tick, so no match that cycle.
   assign set_match      = tick && !count_wr && (count_q == compare_q);

   assign bus.data_ready = (state_q == RESP);
   assign bus.data_out   = data_out_q;

   always_comb begin
      rdata = '0;
      case (bus.address)
         TIMER_CTRL:     rdata = {13'd0, ctrl_q};
         TIMER_PRESCALE: rdata = prescale_q;
         TIMER_COUNT:    rdata = count_q;
         TIMER_COMPARE:  rdata = compare_q;
         TIMER_STATUS:   rdata = {15'd0, match_q};
         default:        rdata = '0;
      endcase
   end

   timer_prescaler u_prescaler (
      .clock    (clock),
      .reset    (reset),
      .run      (ctrl_q[CTRL_RUN]),
      .prescale (prescale_q),
      .clear    (prescale_clear),
      .tick     (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         ctrl_q     <= '0;
         prescale_q <= RESET_PRESCALE;
         count_q    <= '0;
         compare_q  <= RESET_COMPARE;
         match_q    <= 1'b0;
         irq        <= 1'b0;
         data_out_q <= '0;
      end else begin
         if (wr && (bus.address == TIMER_CTRL))     ctrl_q     <= bus.data_in[2:0];
         if (wr && (bus.address == TIMER_PRESCALE)) prescale_q <= bus.data_in;
         if (wr && (bus.address == TIMER_COMPARE))  compare_q  <= bus.data_in;

         if (count_wr) begin
            count_q <= bus.data_in;
         end else if (tick) begin
            count_q <= (set_match && ctrl_q[CTRL_AUTO_RELOAD]) ? 16'd0 : count_q + 16'd1;
         end

         // A new match beats a same-cycle write-1-to-clear.
         if (set_match) begin
            match_q <= 1'b1;
         end else if (wr && (bus.address == TIMER_STATUS) && bus.data_in[0]) begin
            match_q <= 1'b0;
         end

         irq <= match_q && ctrl_q[CTRL_IRQ_EN];

         if (rd) data_out_q <= rdata;
      end
   end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral: register reset values, prescaled
// counting, interrupt handling, wrap, same-cycle collisions and held requests.
module tb_timer_peripheral;

   logic clock;
   logic reset;
   logic irq;
   int   total = 0;
   int   bad   = 0;

   memory_bus bus_if ();

   timer_peripheral dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if),
      .irq   (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One access: enable raised at a negedge, acknowledged one cycle later.
   task automatic xfer(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] rdata);
      @(negedge clock);
      check("ready_low_before", {15'd0, bus_if.data_ready}, 16'd0);
      bus_if.enable       = 1'b1;
      bus_if.write_enable = we;
      bus_if.address      = addr;
      bus_if.data_in      = wdata;
      @(negedge clock);
      check("ready_high_after", {15'd0, bus_if.data_ready}, 16'd1);
      rdata               = bus_if.data_out;
      bus_if.enable       = 1'b0;
      bus_if.write_enable = 1'b0;
   endtask

   task automatic wr_reg(input logic [15:0] addr, input logic [15:0] wdata);
      logic [15:0] dummy;
      xfer(1'b1, addr, wdata, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      logic [15:0] rdata;
      xfer(1'b0, addr, 16'd0, rdata);
      check(tag, rdata, exp);
   endtask

   initial begin
      logic [15:0] count_seq [13];
      int          pulses;

      count_seq = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3,
                    16'd3, 16'd4, 16'd4, 16'd5, 16'd5, 16'd0};

      reset               = 1'b1;
      bus_if.enable       = 1'b0;
      bus_if.write_enable = 1'b0;
      bus_if.address      = '0;
      bus_if.data_in      = '0;
      repeat (3) @(negedge clock);
      check("reset_ready", {15'd0, bus_if.data_ready}, 16'd0);
      check("reset_data_out", bus_if.data_out, 16'd0);
      check("reset_irq", {15'd0, irq}, 16'd0);
      reset = 1'b0;

      // Reset values of the register map.
      rd_chk("rst_ctrl", 16'd0, 16'h0000);
      rd_chk("rst_prescale", 16'd1, 16'h0000);
      rd_chk("rst_count", 16'd2, 16'h0000);
      rd_chk("rst_compare", 16'd3, 16'hFFFF);
      rd_chk("rst_status", 16'd4, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'd0);

      // Divide by 4, compare 5, auto-reload; reads land every 2 cycles.
      wr_reg(16'd1, 16'd3);
      wr_reg(16'd3, 16'd5);
      wr_reg(16'd0, 16'h0003);
      for (int i = 0; i < 13; i++) rd_chk($sformatf("seq_count%0d", i), 16'd2, count_seq[i]);
      rd_chk("seq_match", 16'd4, 16'h0001);
      check("seq_irq_masked", {15'd0, irq}, 16'd0);

      // Enable irq with match pending, then clear it.
      wr_reg(16'd0, 16'h0007);
      check("irq_not_yet", {15'd0, irq}, 16'd0);
      @(negedge clock);
      check("irq_raised", {15'd0, irq}, 16'd1);
      wr_reg(16'd4, 16'h0001);
      check("irq_lags_clear", {15'd0, irq}, 16'd1);
      @(negedge clock);
      check("irq_dropped", {15'd0, irq}, 16'd0);
      rd_chk("status_cleared", 16'd4, 16'h0000);
      wr_reg(16'd0, 16'h0000);

      // Free-running wrap past 0xFFFF with compare at 0xFFFF.
      wr_reg(16'd4, 16'h0001);
      wr_reg(16'd1, 16'h0000);
      wr_reg(16'd3, 16'hFFFF);
      wr_reg(16'd2, 16'hFFFE);
      rd_chk("wrap_loaded", 16'd2, 16'hFFFE);
      wr_reg(16'd0, 16'h0001);
      rd_chk("wrap_ffff", 16'd2, 16'hFFFF);
      wr_reg(16'd0, 16'h0000);
      rd_chk("wrap_after", 16'd2, 16'h0002);
      rd_chk("wrap_match", 16'd4, 16'h0001);

      // COUNT write on a tick, and STATUS clear on a new match.
      wr_reg(16'd4, 16'h0001);
      rd_chk("coll_status_pre", 16'd4, 16'h0000);
      wr_reg(16'd1, 16'h0001);
      wr_reg(16'd3, 16'h0011);
      wr_reg(16'd0, 16'h0001);
      wr_reg(16'd2, 16'h0010);
      rd_chk("coll_count_load", 16'd2, 16'h0010);
      wr_reg(16'd4, 16'h0001);
      rd_chk("coll_match_kept", 16'd4, 16'h0001);
      rd_chk("coll_count_later", 16'd2, 16'h0013);
      wr_reg(16'd0, 16'h0000);

      // Held write to an unmapped offset: one access per two cycles.
      @(negedge clock);
      bus_if.enable       = 1'b1;
      bus_if.write_enable = 1'b1;
      bus_if.address      = 16'd7;
      bus_if.data_in      = 16'hABCD;
      pulses              = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (bus_if.data_ready) pulses++;
      end
      bus_if.enable       = 1'b0;
      bus_if.write_enable = 1'b0;
      check("held_pulses", 16'(pulses), 16'd3);
      rd_chk("unmapped_read", 16'd7, 16'h0000);
      rd_chk("held_ctrl", 16'd0, 16'h0000);
      rd_chk("held_prescale", 16'd1, 16'h0001);
      rd_chk("held_count", 16'd2, 16'h0015);
      rd_chk("held_compare", 16'd3, 16'h0011);
      rd_chk("held_status", 16'd4, 16'h0001);
      check("held_irq", {15'd0, irq}, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
